// File: rtl/sevseg_pkg.sv
// Shared types and glyph constants for the BCD seven-segment display scanner.
// Segment bit order is a..g = bit0..bit6, active-high.
package sevseg_pkg;

    typedef enum logic [1:0] {
        SHOW_O = 2'd0,
        GAP_O  = 2'd1,
        SHOW_T = 2'd2,
        GAP_T  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;

endpackage

// File: rtl/bcd_to_sevseg.sv
// Combinational BCD digit to seven-segment glyph decoder.
// Non-BCD codes (10..15) render as a dash so bad upstream data is visible.
module bcd_to_sevseg
    import sevseg_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    // Glyph lookup
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed seven-segment scanner with pending/display register
// pair; new values only reach the display at the end of GAP_T (no tearing).
// Optional feature macro: BCD_DISPLAY_SCANNER_ZERO_BLANK_EN blanks a leading
// zero in the tens position.
module bcd_display_scanner
    import sevseg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLANK_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [3:0]  tens,
    input  logic [3:0]  ones,
    output logic [6:0]  seg,
    output logic [1:0]  an,
    output logic        frame
);

    localparam int MAXL = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXL);

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    bcd_pair_t      pend, disp, disp_nxt;
    logic           pend_vld;

    logic           last, frame_now, acc, xfer;
    bcd_digit_t     dig;
    logic [6:0]     glyph;
    logic [6:0]     seg_nxt;
    logic [1:0]     an_nxt;
    logic           frame_nxt;

    assign in_rdy = ~pend_vld;
    assign acc    = in_val & ~pend_vld;

    // Single shared decoder; the digit it sees follows the upcoming state
    bcd_to_sevseg u_dec (
        .digit (dig),
        .seg   (glyph)
    );

    // Next-state, transfer and look-ahead output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        last      = (state == SHOW_O || state == SHOW_T) ? (cnt == SHOW_LAST)
                                                         : (cnt == GAP_LAST);
        if (last) begin
            cnt_nxt = '0;
            case (state)
                SHOW_O:  state_nxt = GAP_O;
                GAP_O:   state_nxt = SHOW_T;
                SHOW_T:  state_nxt = GAP_T;
                default: state_nxt = SHOW_O;
            endcase
        end

        frame_now = (state == GAP_T) && last;
        xfer      = frame_now && pend_vld;
        disp_nxt  = xfer ? pend : disp;

        dig = (state_nxt == SHOW_T) ? disp_nxt.tens : disp_nxt.ones;

        seg_nxt = SEG_OFF;
        an_nxt  = 2'b00;
        case (state_nxt)
            SHOW_O: begin
                an_nxt  = 2'b01;
                seg_nxt = glyph;
            end
            SHOW_T: begin
                an_nxt  = 2'b10;
`ifdef BCD_DISPLAY_SCANNER_ZERO_BLANK_EN
                seg_nxt = (disp_nxt.tens == 4'd0) ? SEG_OFF : glyph;
`else
                seg_nxt = glyph;
`endif
            end
            default: begin
                an_nxt  = 2'b00;
                seg_nxt = SEG_OFF;
            end
        endcase

        frame_nxt = (state_nxt == GAP_T) && (cnt_nxt == GAP_LAST);
    end

    // Scan FSM, handshake registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHOW_O;
            cnt      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            disp     <= '0;
            seg      <= SEG_OFF;
            an       <= 2'b00;
            frame    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            disp  <= disp_nxt;
            seg   <= seg_nxt;
            an    <= an_nxt;
            frame <= frame_nxt;
            // A new accept wins over a transfer so pend stays occupied
            if (acc) begin
                pend     <= '{tens: tens, ones: ones};
                pend_vld <= 1'b1;
            end else if (xfer) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (REFRESH_CYCLES=8, BLANK_CYCLES=2).
// The reference model tracks frame position as edges-since-reset modulo the
// frame length and applies the handshake rules per edge.
module tb_bcd_display_scanner;

    localparam int R = 8;
    localparam int B = 2;
    localparam int P = 2 * (R + B);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_val = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       in_rdy;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    bcd_display_scanner #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .tens   (tens),
        .ones   (ones),
        .seg    (seg),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int         p = 0;
    logic       m_pv = 1'b0;
    logic [3:0] m_pt = 4'd0, m_po = 4'd0, m_dt = 4'd0, m_do = 4'd0;

    logic [6:0] glyph_tbl [16];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg();
        int q;
        if (p == 0) return 7'h00;
        q = p % P;
        if (q < R) return glyph_tbl[m_do];
        if (q < R + B) return 7'h00;
        if (q < 2 * R + B) begin
`ifdef BCD_DISPLAY_SCANNER_ZERO_BLANK_EN
            if (m_dt == 4'd0) return 7'h00;
`endif
            return glyph_tbl[m_dt];
        end
        return 7'h00;
    endfunction

    function automatic logic [1:0] exp_an();
        int q;
        if (p == 0) return 2'b00;
        q = p % P;
        if (q < R) return 2'b01;
        if (q >= R + B && q < 2 * R + B) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check_outs();
        check("seg", 32'(seg), 32'(exp_seg()));
        check("an", 32'(an), 32'(exp_an()));
        check("frame", 32'(frame), 32'(p > 0 && (p % P) == P - 1));
        check("in_rdy", 32'(in_rdy), 32'(!m_pv));
    endtask

    // one clock: model update at posedge, compare at negedge
    task automatic step();
        logic acc, xf;
        @(posedge clk);
        acc = in_val && !m_pv;
        xf  = (p > 0) && ((p % P) == P - 1) && m_pv;
        if (xf) begin
            m_dt = m_pt;
            m_do = m_po;
        end
        if (acc) begin
            m_pt = tens;
            m_po = ones;
            m_pv = 1'b1;
        end else if (xf) begin
            m_pv = 1'b0;
        end
        p++;
        @(negedge clk);
        check_outs();
    endtask

    task automatic send(input logic [3:0] t, input logic [3:0] o);
        check("rdy_before_send", 32'(in_rdy), 32'd1);
        tens   = t;
        ones   = o;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * P && (p % P) != target; i++) step();
        check("run_to", 32'(p % P), 32'(target));
    endtask

    task automatic model_reset();
        p    = 0;
        m_pv = 1'b0;
        m_pt = 4'd0; m_po = 4'd0;
        m_dt = 4'd0; m_do = 4'd0;
    endtask

    initial begin
        int n_o, n_t, n_dark;
        glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

        // power-on reset
        repeat (3) @(negedge clk);
        check_outs();
        rst_n = 1'b1;
        model_reset();

        // 1. reset asserted mid SHOW_T
        run_to(R + B + 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_an", 32'(an), 32'h0);
        check("rst_rdy", 32'(in_rdy), 32'h1);
        check("rst_frame", 32'(frame), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_an", 32'(an), 32'h1);
        check("rel_seg", 32'(seg), 32'h3F);

        // 2. accept 31
        send(4'd3, 4'd1);
        check("rdy_drop", 32'(in_rdy), 32'h0);
        run_to(1);
        check("t2_ones", 32'(seg), 32'h06);
        check("t2_an_o", 32'(an), 32'h1);
        run_to(R + B + 1);
        check("t2_tens", 32'(seg), 32'h4F);
        check("t2_an_t", 32'(an), 32'h2);
        check("t2_rdy", 32'(in_rdy), 32'h1);

        // 3. back-pressure: 19 offered while pend holds 25
        send(4'd2, 4'd5);
        tens = 4'd1; ones = 4'd9; in_val = 1'b1;
        repeat (3) step();
        in_val = 1'b0;
        run_to(1);
        check("t3_ones", 32'(seg), 32'h6D);
        run_to(R + B + 1);
        check("t3_tens", 32'(seg), 32'h5B);

        // 4. new value offered across the frame boundary
        send(4'd4, 4'd2);
        run_to(P - 2);
        tens = 4'd6; ones = 4'd8; in_val = 1'b1;
        step();
        check("t4_frame", 32'(frame), 32'h1);
        check("t4_rdy_f", 32'(in_rdy), 32'h0);
        step();
        check("t4_rdy_free", 32'(in_rdy), 32'h1);
        check("t4_old_ones", 32'(seg), 32'h5B);
        step();
        in_val = 1'b0;
        check("t4_rdy_full", 32'(in_rdy), 32'h0);
        run_to(R + B + 1);
        check("t4_old_tens", 32'(seg), 32'h66);
        run_to(1);
        check("t4_new_ones", 32'(seg), 32'h7F);
        run_to(R + B + 1);
        check("t4_new_tens", 32'(seg), 32'h7D);

        // 5. invalid BCD
        send(4'hC, 4'hF);
        run_to(1);
        check("t5_ones", 32'(seg), 32'h40);
        run_to(R + B + 1);
        check("t5_tens", 32'(seg), 32'h40);

        // 6. timing and leading zero with 07
        send(4'd0, 4'd7);
        run_to(0);
        run_to(0);
        n_o = 0; n_t = 0; n_dark = 0;
        for (int i = 0; i < P; i++) begin
            step();
            if (an == 2'b01) n_o++;
            else if (an == 2'b10) n_t++;
            else if (an == 2'b00 && seg == 7'h00) n_dark++;
        end
        check("t6_show_o_len", 32'(n_o), 32'(R));
        check("t6_show_t_len", 32'(n_t), 32'(R));
        check("t6_gap_len", 32'(n_dark), 32'(2 * B));
        run_to(R + B + 1);
`ifdef BCD_DISPLAY_SCANNER_ZERO_BLANK_EN
        check("t6_tens_zero", 32'(seg), 32'h00);
`else
        check("t6_tens_zero", 32'(seg), 32'h3F);
`endif
        run_to(1);
        check("t6_ones", 32'(seg), 32'h07);

        // 7. random traffic
        for (int i = 0; i < 600; i++) begin
            in_val = 1'($urandom_range(0, 1));
            tens   = 4'($urandom);
            ones   = 4'($urandom);
            step();
        end
        in_val = 1'b0;

        // 8. reset with a value pending discards it
        run_to(R + B + 2);
        if (!m_pv) send(4'd9, 4'd9);
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_rdy", 32'(in_rdy), 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * P + 3) step();
        check("t8_disp_zero", 32'(seg), 32'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // hard stop in case a wait never returns
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
